audio_dac4_sd: RTL and testbench

Stereo PCM-to-4-bit audio DAC front-end that feeds the board's 4-bit resistor-ladder `audio_l`/`audio_r` pins. It accepts 16-bit signed L/R sample pairs over a valid/ready handshake into a small FIFO. Samples are released at a fixed sample rate, and each channel passes through a first-order error-feedback noise shaper running every clock. It sits between the system's audio source and the top-level audio pins, and replaces the single-bit `C_loudness` pin selection with full 4-bit drive.

---
 rtl/audio_pkg.sv | 10 +
 rtl/sd_mod1.sv | 34 +++
 rtl/audio_dac4_sd.sv | 89 ++++++++
 tb/tb_audio_dac4_sd.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the 4-bit stereo audio DAC front-end.
package audio_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [3:0] dac_code_t;
    typedef enum logic [1:0] {IDLE, RUN, UNDERRUN} state_t;

    localparam dac_code_t MIDSCALE = 4'h8;

endpackage

// File: rtl/sd_mod1.sv
// sd_mod1: first-order error-feedback noise shaper, 16-bit PCM to a registered 4-bit code.
module sd_mod1
    import audio_pkg::*;
(
    input  logic      clk_audio,
    input  logic      reset,
    input  sample_t   hold,
    output dac_code_t out
);

    logic [11:0] err_q, err_d;
    dac_code_t   out_q, out_d;
    logic [16:0] acc;

    // Offset binary plus carried error; a carry out saturates to full scale.
    always_comb begin
        acc   = {1'b0, hold ^ 16'h8000} + {5'b0, err_q};
        out_d = acc[16] ? 4'hF : acc[15:12];
        err_d = acc[16] ? 12'hFFF : acc[11:0];
    end

    always_ff @(posedge clk_audio or posedge reset) begin
        if (reset) begin
            err_q <= '0;
            out_q <= MIDSCALE;
        end else begin
            err_q <= err_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/audio_dac4_sd.sv
// audio_dac4_sd: stereo PCM FIFO with fixed-rate sample release into two 4-bit noise-shaped DAC outputs.
module audio_dac4_sd
    import audio_pkg::*;
#(
    parameter int C_sample_div = 256,
    parameter int C_fifo_depth = 4
) (
    input  logic        clk_audio,
    input  logic        reset,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  audio_l,
    output logic [3:0]  audio_r,
    output logic        underrun,
    input  logic        clr_underrun
);

    localparam int AW = $clog2(C_fifo_depth);
    localparam int CW = AW + 1;

    sample_t         mem_l_q [C_fifo_depth];
    sample_t         mem_r_q [C_fifo_depth];
    logic [15:0]     cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            underrun_q, underrun_d;
    state_t          state_q, state_d;
    sample_t         hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic            tick, empty, push, pop;

    always_comb begin
        tick       = cnt_q == 16'(C_sample_div - 1);
        cnt_d      = tick ? '0 : cnt_q + 16'd1;
        empty      = count_q == '0;
        push       = in_valid && in_ready_q;
        pop        = tick && !empty;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        in_ready_d = count_d != CW'(C_fifo_depth);
        // Any tick with data pops; an empty tick only matters once running.
        state_d    = pop ? RUN : (tick && state_q == RUN) ? UNDERRUN : state_q;
        hold_l_d   = pop ? mem_l_q[rd_ptr_q] : (state_q == IDLE) ? '0 : hold_l_q;
        hold_r_d   = pop ? mem_r_q[rd_ptr_q] : (state_q == IDLE) ? '0 : hold_r_q;
        underrun_d = (tick && empty && state_q != IDLE) || (underrun_q && !clr_underrun);
    end

    always_ff @(posedge clk_audio or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            underrun_q <= 1'b0;
            state_q    <= IDLE;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            underrun_q <= underrun_d;
            state_q    <= state_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_audio) begin
        if (push) begin
            mem_l_q[wr_ptr_q] <= in_l;
            mem_r_q[wr_ptr_q] <= in_r;
        end
    end

    sd_mod1 u_mod_l (.clk_audio(clk_audio), .reset(reset), .hold(hold_l_q), .out(audio_l));
    sd_mod1 u_mod_r (.clk_audio(clk_audio), .reset(reset), .hold(hold_r_q), .out(audio_r));

    assign in_ready = in_ready_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_dac4_sd.sv
// tb_audio_dac4_sd: directed tests for audio_dac4_sd with an 8-clock sample period.
module tb_audio_dac4_sd;

    localparam int SD = 8;

    logic        clk_audio = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        in_valid = 1'b0;
    logic        clr_underrun = 1'b0;
    logic        in_ready;
    logic [3:0]  audio_l, audio_r;
    logic        underrun;
    int          tests = 0;
    int          fails = 0;
    int          edges;

    audio_dac4_sd #(.C_sample_div(SD), .C_fifo_depth(4)) dut (
        .clk_audio(clk_audio), .reset(reset), .in_l(in_l), .in_r(in_r),
        .in_valid(in_valid), .in_ready(in_ready), .audio_l(audio_l),
        .audio_r(audio_r), .underrun(underrun), .clr_underrun(clr_underrun)
    );

    always #5 clk_audio = ~clk_audio;

    // Edges since reset release; the sample tick falls on every multiple of SD.
    always @(posedge clk_audio or posedge reset) edges <= reset ? 0 : edges + 1;

    task automatic step;
        @(posedge clk_audio);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        clr_underrun = 1'b0;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, output int at);
        int n = 0;
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            step;
            n++;
        end
        step;
        at = edges;
        in_valid = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        int n = 0;
        while (edges < e && n < 200) begin
            step;
            n++;
        end
        tests++;
        if (edges != e) begin
            fails++;
            $display("FAIL wait_edge: at edge %0d, required edge %0d", edges, e);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        tests += 4;
        if (audio_l !== 4'h8) begin fails++; $display("FAIL reset_audio_l: got %h, expected 8", audio_l); end
        if (audio_r !== 4'h8) begin fails++; $display("FAIL reset_audio_r: got %h, expected 8", audio_r); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b, expected 0", underrun); end
    endtask

    task automatic test_silence;
        int at;
        do_reset;
        push(16'h0000, 16'h0000, at);
        wait_edge(SD + 1);
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (audio_l !== 4'h8 || audio_r !== 4'h8) begin
                fails++;
                $display("FAIL silence[%0d]: got l=%h r=%h, expected 8/8", i, audio_l, audio_r);
            end
            step;
        end
    endtask

    task automatic test_extremes;
        int at;
        do_reset;
        push(16'h7FFF, 16'h8000, at);
        wait_edge(SD + 1);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (audio_l !== 4'hF || audio_r !== 4'h0) begin
                fails++;
                $display("FAIL extremes[%0d]: got l=%h r=%h, expected F/0", i, audio_l, audio_r);
            end
            step;
        end
    endtask

    task automatic test_noise_shaping;
        int at;
        int sum = 0;
        logic [3:0] exp;
        do_reset;
        push(16'h0800, 16'h0000, at);
        wait_edge(SD + 1);
        for (int i = 0; i < 16; i++) begin
            exp = (i % 2 == 1) ? 4'h9 : 4'h8;
            tests++;
            if (audio_l !== exp || audio_r !== 4'h8) begin
                fails++;
                $display("FAIL noise[%0d]: got l=%h r=%h, expected %h/8", i, audio_l, audio_r, exp);
            end
            sum += int'(audio_l);
            step;
        end
        tests++;
        if (sum != 136) begin fails++; $display("FAIL noise_mean: sum over 16 got %0d, expected 136", sum); end
    endtask

    task automatic test_back_to_back;
        int at [6];
        do_reset;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    push(16'(k * 4096), 16'(-(k * 4096)), at[k]);
                    if (k == 3) begin
                        tests++;
                        if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b, expected 0", in_ready); end
                    end
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_edge(SD * (k + 1) + 1);
                    tests++;
                    if (audio_l !== 4'(8 + k) || audio_r !== 4'(8 - k)) begin
                        fails++;
                        $display("FAIL order[%0d]: got l=%h r=%h, expected %h/%h", k, audio_l, audio_r, 4'(8 + k), 4'(8 - k));
                    end
                end
            end
        join
        tests += 3;
        if (at[3] != 4) begin fails++; $display("FAIL push4_edge: got %0d, expected 4", at[3]); end
        if (at[4] != SD + 1) begin fails++; $display("FAIL push5_edge: got %0d, expected %0d", at[4], SD + 1); end
        if (at[5] != 2 * SD + 1) begin fails++; $display("FAIL push6_edge: got %0d, expected %0d", at[5], 2 * SD + 1); end
    endtask

    task automatic test_underrun;
        int at;
        do_reset;
        push(16'h1000, 16'h1000, at);
        wait_edge(2 * SD - 1);
        tests++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_early: got %b, expected 0", underrun); end
        step;
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_set: got %b, expected 1", underrun); end
        push(16'h2000, 16'h2000, at);
        tests++;
        if (audio_l !== 4'h9) begin fails++; $display("FAIL underrun_repeat: got %h, expected 9", audio_l); end
        wait_edge(3 * SD + 1);
        tests += 2;
        if (audio_l !== 4'hA) begin fails++; $display("FAIL resume_audio: got %h, expected A", audio_l); end
        if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_sticky: got %b, expected 1", underrun); end
        clr_underrun = 1'b1;
        step;
        clr_underrun = 1'b0;
        tests++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear: got %b, expected 0", underrun); end
        wait_edge(4 * SD - 1);
        clr_underrun = 1'b1;
        step;
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL set_beats_clear: got %b, expected 1", underrun); end
        step;
        clr_underrun = 1'b0;
        tests++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear2: got %b, expected 0", underrun); end
    endtask

    task automatic test_reset_mid;
        int at;
        do_reset;
        push(16'h7FFF, 16'h7FFF, at);
        for (int k = 0; k < 3; k++) push(16'h3000, 16'h3000, at);
        wait_edge(SD + 1);
        tests++;
        if (audio_l !== 4'hF) begin fails++; $display("FAIL pre_reset_audio: got %h, expected F", audio_l); end
        #2;
        reset = 1'b1;
        #1;
        tests += 3;
        if (audio_l !== 4'h8 || audio_r !== 4'h8) begin fails++; $display("FAIL midreset_audio: got l=%h r=%h, expected 8/8", audio_l, audio_r); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b, expected 1", in_ready); end
        if (underrun !== 1'b0) begin fails++; $display("FAIL midreset_underrun: got %b, expected 0", underrun); end
        step;
        reset = 1'b0;
        wait_edge(SD + 2);
        tests += 2;
        if (audio_l !== 4'h8 || audio_r !== 4'h8) begin fails++; $display("FAIL stale_data: got l=%h r=%h, expected 8/8", audio_l, audio_r); end
        if (underrun !== 1'b0) begin fails++; $display("FAIL idle_underrun: got %b, expected 0", underrun); end
    endtask

    initial begin
        test_reset;
        test_silence;
        test_extremes;
        test_noise_shaping;
        test_back_to_back;
        test_underrun;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
